matrix_mul_transpose_seq: RTL and testbench

MATRIX_MUL_TRANSPOSE_SEQ -- requirements
Module: matrix_mul_transpose_seq

---
 rtl/matrix_mul_transpose_seq_pkg.sv | 35 +++
 rtl/matrix_mul_transpose_seq_mac_unit.sv | 41 ++++
 rtl/matrix_mul_transpose_seq.sv | 137 +++++++++++++
 tb/tb_matrix_mul_transpose_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/matrix_mul_transpose_seq_pkg.sv
// Shared configuration for matrix_mul_transpose_seq: packed-port macros, FSM encodings and state type.
// Optional feature switch: define MATRIXMUL_SAT_EN to make the MAC saturate instead of wrap.
`ifndef MATRIX_MUL_TRANSPOSE_SEQ_CONFIG
`define MATRIX_MUL_TRANSPOSE_SEQ_CONFIG

`define PORT_2D(rows, cols, w) [(rows)*(cols)*(w)-1:0]
`define DEFINE_PACK_VAR(name, rows, cols, w) logic [(rows)*(cols)*(w)-1:0] name;
`define PACK_2D_ARRAY(rows, cols, w, src, dst) \
    for (genvar pk_r = 0; pk_r < (rows); pk_r++) begin : g_pack_r \
        for (genvar pk_c = 0; pk_c < (cols); pk_c++) begin : g_pack_c \
            assign dst[(pk_r*(cols)+pk_c)*(w) +: (w)] = src[pk_r][pk_c]; \
        end \
    end
`define UNPACK_2D_ARRAY(rows, cols, w, src, dst) \
    for (genvar up_r = 0; up_r < (rows); up_r++) begin : g_unpack_r \
        for (genvar up_c = 0; up_c < (cols); up_c++) begin : g_unpack_c \
            assign dst[up_r][up_c] = src[(up_r*(cols)+up_c)*(w) +: (w)]; \
        end \
    end

`define STATE_IDLE 2'd0
`define STATE_RUN  2'd1
`define STATE_DONE 2'd2

`endif

package matrix_mul_transpose_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = `STATE_IDLE,
        RUN  = `STATE_RUN,
        DONE = `STATE_DONE
    } state_t;

endpackage

// File: rtl/matrix_mul_transpose_seq_mac_unit.sv
// Single multiply-accumulate step; wraps mod 2^w by default, clamps when MATRIXMUL_SAT_EN is defined.
module mac_unit
    import matrix_mul_transpose_seq_pkg::*;
#(
    parameter int bitlength = 8
) (
    input  logic                 clear,
    input  logic [bitlength-1:0] acc,
    input  logic [bitlength-1:0] a,
    input  logic [bitlength-1:0] b,
    output logic [bitlength-1:0] sum
);

    logic [bitlength-1:0] base;

`ifdef MATRIXMUL_SAT_EN
    localparam logic [2*bitlength:0] MAX_VAL = {{(bitlength+1){1'b0}}, {bitlength{1'b1}}};

    logic [2*bitlength-1:0] product;
    logic [2*bitlength:0]   wide;

    // Full-precision sum, clamped to the largest element value.
    always_comb begin
        base    = clear ? {bitlength{1'b0}} : acc;
        product = {{bitlength{1'b0}}, a} * {{bitlength{1'b0}}, b};
        wide    = {{(bitlength+1){1'b0}}, base} + {1'b0, product};
        if (wide > MAX_VAL) begin
            sum = {bitlength{1'b1}};
        end else begin
            sum = wide[bitlength-1:0];
        end
    end
`else
    // Sum evaluated in element width, so the product and carry wrap naturally.
    always_comb begin
        base = clear ? {bitlength{1'b0}} : acc;
        sum  = base + a * b;
    end
`endif

endmodule

// File: rtl/matrix_mul_transpose_seq.sv
// Sequential C = A * B^T, one MAC per cycle. Build option: MATRIXMUL_SAT_EN (saturating MAC).
module matrix_mul_transpose_seq
    import matrix_mul_transpose_seq_pkg::*;
#(
    parameter int bitlength = 8,
    parameter int M1_D1     = 3,
    parameter int M1_D2     = 4,
    parameter int M2_D2     = 2
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           start,
    input  logic `PORT_2D(M1_D1, M2_D2, bitlength)         AI,
    input  logic `PORT_2D(M1_D2, M2_D2, bitlength)         BI,
    output logic `PORT_2D(M1_D1, M1_D2, bitlength)         CO,
    output logic                                           busy,
    output logic                                           done
);

    localparam int IW = $clog2(M1_D1 + 1);
    localparam int JW = $clog2(M1_D2 + 1);
    localparam int KW = $clog2(M2_D2 + 1);

    state_t                                    state;
    logic [IW-1:0]                             i;
    logic [JW-1:0]                             j;
    logic [KW-1:0]                             k;
    logic [bitlength-1:0]                      acc;
    logic `PORT_2D(M1_D1, M2_D2, bitlength)    a_lat;
    logic `PORT_2D(M1_D2, M2_D2, bitlength)    b_lat;
    logic [bitlength-1:0]                      a_elem;
    logic [bitlength-1:0]                      b_elem;
    logic [bitlength-1:0]                      mac_sum;
    logic                                      k_first;
    logic                                      k_last;

    // Operand select: OR of masked slices keeps all indices constant.
    always_comb begin
        a_elem = {bitlength{1'b0}};
        b_elem = {bitlength{1'b0}};
        for (int r = 0; r < M1_D1; r++) begin
            for (int c = 0; c < M2_D2; c++) begin
                a_elem = a_elem | (((r + 1 == int'(i)) && (c + 1 == int'(k))) ?
                         a_lat[(r*M2_D2+c)*bitlength +: bitlength] : {bitlength{1'b0}});
            end
        end
        for (int r = 0; r < M1_D2; r++) begin
            for (int c = 0; c < M2_D2; c++) begin
                b_elem = b_elem | (((r + 1 == int'(j)) && (c + 1 == int'(k))) ?
                         b_lat[(r*M2_D2+c)*bitlength +: bitlength] : {bitlength{1'b0}});
            end
        end
        k_first = (k == KW'(1));
        k_last  = (k == KW'(M2_D2));
    end

    mac_unit #(
        .bitlength(bitlength)
    ) u_mac (
        .clear(k_first),
        .acc  (acc),
        .a    (a_elem),
        .b    (b_elem),
        .sum  (mac_sum)
    );

    // Control FSM, index counters and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            CO    <= '0;
            acc   <= {bitlength{1'b0}};
            i     <= IW'(1);
            j     <= JW'(1);
            k     <= KW'(1);
            a_lat <= '0;
            b_lat <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_lat <= AI;
                        b_lat <= BI;
                        i     <= IW'(1);
                        j     <= JW'(1);
                        k     <= KW'(1);
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    acc <= mac_sum;
                    if (k_last) begin
                        for (int r = 0; r < M1_D1; r++) begin
                            for (int c = 0; c < M1_D2; c++) begin
                                if ((r + 1 == int'(i)) && (c + 1 == int'(j))) begin
                                    CO[(r*M1_D2+c)*bitlength +: bitlength] <= mac_sum;
                                end
                            end
                        end
                        k <= KW'(1);
                        if (j == JW'(M1_D2)) begin
                            j <= JW'(1);
                            if (i == IW'(M1_D1)) begin
                                i     <= IW'(1);
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                i <= i + IW'(1);
                            end
                        end else begin
                            j <= j + JW'(1);
                        end
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mul_transpose_seq.sv
// Directed vector bench for matrix_mul_transpose_seq at default sizes (3x2 * (4x2)^T).
module tb_matrix_mul_transpose_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [47:0] ai;
    logic [63:0] bi;
    logic [95:0] co;
    logic        busy;
    logic        done;

    int applied     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    matrix_mul_transpose_seq #(
        .bitlength(8), .M1_D1(3), .M1_D2(4), .M2_D2(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .AI(ai), .BI(bi),
        .CO(co), .busy(busy), .done(done)
    );

    typedef struct {
        string       name;
        logic [47:0] a;
        logic [63:0] b;
        logic [95:0] c;
    } vec_t;

    vec_t vecs[4];

`ifdef MATRIXMUL_SAT_EN
    localparam logic [7:0] BIG = 8'd255;
`else
    localparam logic [7:0] BIG = 8'd0;
`endif

    function automatic logic [47:0] mk_a(input logic [7:0] a11, a12, a21, a22, a31, a32);
        return {a32, a31, a22, a21, a12, a11};
    endfunction

    function automatic logic [63:0] mk_b(input logic [7:0] b11, b12, b21, b22, b31, b32, b41, b42);
        return {b42, b41, b32, b31, b22, b21, b12, b11};
    endfunction

    function automatic logic [95:0] mk_c(input logic [7:0] c11, c12, c13, c14,
                                         c21, c22, c23, c24, c31, c32, c33, c34);
        return {c34, c33, c32, c31, c24, c23, c22, c21, c14, c13, c12, c11};
    endfunction

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Pulse start with the given operands; lat = edges after the start edge until done (0 = timeout).
    task automatic run_vec(input logic [47:0] a, input logic [63:0] b, output int lat);
        int n;
        @(negedge clk);
        ai    = a;
        bi    = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        n   = 0;
        while (lat == 0 && n < 40) begin
            n++;
            @(posedge clk);
            #1;
            if (done) lat = n;
        end
    endtask

    initial begin
        int lat;
        int n;
        int nd;
        int low_cnt;
        int d_edge[3];

        vecs[0] = '{"ones_x_rowj", mk_a(1,1,1,1,1,1), mk_b(1,1,2,2,3,3,4,4),
                    mk_c(2,4,6,8, 2,4,6,8, 2,4,6,8)};
        vecs[1] = '{"sixteens", mk_a(16,16,16,16,16,16), mk_b(16,16,16,16,16,16,16,16),
                    mk_c(BIG,BIG,BIG,BIG, BIG,BIG,BIG,BIG, BIG,BIG,BIG,BIG)};
        vecs[2] = '{"mixed", mk_a(2,3,1,4,5,0), mk_b(1,1,2,0,0,3,10,10),
                    mk_c(5,4,9,50, 5,2,12,50, 5,10,0,50)};
        vecs[3] = '{"identity_like", mk_a(1,0,0,1,1,1), mk_b(3,5,7,2,0,9,4,4),
                    mk_c(3,7,0,4, 5,2,9,4, 8,9,9,8)};

        rst   = 1'b1;
        start = 1'b0;
        ai    = '0;
        bi    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {95'd0, busy}, 96'd0);
        check("reset_done", {95'd0, done}, 96'd0);
        check("reset_co", co, 96'd0);
        @(negedge clk) rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            run_vec(vecs[v].a, vecs[v].b, lat);
            check({vecs[v].name, "_latency"}, 96'(lat), 96'd24);
            check({vecs[v].name, "_busy_at_done"}, {95'd0, busy}, 96'd1);
            check({vecs[v].name, "_co"}, co, vecs[v].c);
            @(posedge clk);
            #1;
            check({vecs[v].name, "_done_width"}, {95'd0, done}, 96'd0);
            check({vecs[v].name, "_busy_idle"}, {95'd0, busy}, 96'd0);
        end

        // Second start plus AI change mid-run must not restart or disturb the latched A.
        @(negedge clk);
        ai    = vecs[0].a;
        bi    = vecs[0].b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        n   = 0;
        while (lat == 0 && n < 40) begin
            n++;
            if (n == 5) begin
                start = 1'b1;
                ai    = vecs[3].a;
            end
            @(posedge clk);
            #1;
            if (n == 5) start = 1'b0;
            if (done) lat = n;
        end
        check("restart_ignored_latency", 96'(lat), 96'd24);
        check("restart_ignored_co", co, vecs[0].c);
        repeat (2) @(posedge clk);

        // Reset at RUN edge 10, then a clean full run.
        @(negedge clk);
        ai    = vecs[2].a;
        bi    = vecs[2].b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrun_reset_busy", {95'd0, busy}, 96'd0);
        check("midrun_reset_done", {95'd0, done}, 96'd0);
        check("midrun_reset_co", co, 96'd0);
        @(negedge clk) rst = 1'b0;
        run_vec(vecs[3].a, vecs[3].b, lat);
        check("after_reset_latency", 96'(lat), 96'd24);
        check("after_reset_co", co, vecs[3].c);
        repeat (2) @(posedge clk);

        // Start held high: three back-to-back runs.
        @(negedge clk);
        ai    = vecs[0].a;
        bi    = vecs[0].b;
        start = 1'b1;
        nd      = 0;
        low_cnt = 0;
        n       = 0;
        d_edge  = '{0, 0, 0};
        while (nd < 3 && n < 100) begin
            n++;
            @(posedge clk);
            #1;
            if (done) begin
                d_edge[nd] = n;
                nd++;
            end
            if (nd == 1 && !busy) low_cnt++;
        end
        start = 1'b0;
        check("held_start_runs", 96'(nd), 96'd3);
        check("held_start_gap1", 96'(d_edge[1] - d_edge[0]), 96'd26);
        check("held_start_gap2", 96'(d_edge[2] - d_edge[1]), 96'd26);
        check("held_start_idle_cycles", 96'(low_cnt), 96'd1);
        repeat (3) @(posedge clk);
        #1;
        check("held_start_final_idle", {95'd0, busy}, 96'd0);
        check("held_start_co", co, vecs[0].c);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
